bs_packer: RTL

BS_PACKER -- requirements
Module: bs_packer

---
 rtl/bs_packer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bs_packer.sv
`timescale 1ns/1ps
// bs_packer: packs variable-length codes (0..IN_WD bits per beat) into DATA_WD-bit words.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   val_i/rdy_o      input beat handshake
//   dat_i, len_i     right-justified code bits and their count (0..IN_WD)
//   flush_i          terminate the stream after this beat's bits
//   val_o/rdy_i      output word handshake
//   dat_o            packed word; byt_o valid bytes; lst_o last word of the stream
//
// LSB_FIRST=1: first stream bit lands at word bit 0 and each code is appended LSB first.
// LSB_FIRST=0: first stream bit lands at the word MSB and each code is appended MSB first.
module bs_packer #(
   parameter int unsigned DATA_WD   = 32,
   parameter int unsigned IN_WD     = 32,
   parameter bit          LSB_FIRST = 1'b1,
   parameter int unsigned LEN_WD    = $clog2(IN_WD) + 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       val_i,
   output logic                       rdy_o,
   input  logic [IN_WD-1:0]           dat_i,
   input  logic [LEN_WD-1:0]          len_i,
   input  logic                       flush_i,
   output logic                       val_o,
   input  logic                       rdy_i,
   output logic [DATA_WD-1:0]         dat_o,
   output logic [$clog2(DATA_WD/8):0] byt_o,
   output logic                       lst_o
);

   localparam int unsigned ACC_WD = 2 * DATA_WD;
   // Wide enough for cnt (< DATA_WD) plus a full beat without overflow.
   localparam int unsigned SUM_WD = $clog2(ACC_WD) + 1;
   localparam int unsigned BYT_WD = $clog2(DATA_WD / 8) + 1;
   localparam logic [SUM_WD-1:0] DW_S     = SUM_WD'(DATA_WD);
   localparam logic [BYT_WD-1:0] BYT_FULL = BYT_WD'(DATA_WD / 8);

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e              state_q, state_d;
   logic [ACC_WD-1:0]   acc_q, acc_d;
   logic [SUM_WD-1:0]   cnt_q, cnt_d;
   logic                val_q, val_d;
   logic [DATA_WD-1:0]  dat_q, dat_d;
   logic [BYT_WD-1:0]   byt_q, byt_d;
   logic                lst_q, lst_d;

   logic                out_free, accept, full;
   logic [IN_WD-1:0]    code;
   logic [ACC_WD-1:0]   code_ext, combined, resid;
   logic [SUM_WD-1:0]   new_cnt, res_cnt;
   logic [DATA_WD-1:0]  word_full;

   // Partial words: LSB-first already sits at the bottom, MSB-first is moved to the top.
   function automatic logic [DATA_WD-1:0] pad_word(input logic [DATA_WD-1:0] w,
                                                   input logic [SUM_WD-1:0]  n);
      logic [DATA_WD-1:0] msb;
      msb = w << (DW_S - n);
      return LSB_FIRST ? w : msb;
   endfunction

   function automatic logic [BYT_WD-1:0] ceil_bytes(input logic [SUM_WD-1:0] n);
      return BYT_WD'((n + SUM_WD'(7)) >> 3);
   endfunction

   assign out_free = !val_q || rdy_i;
   assign rdy_o    = (state_q == StRun) && out_free;
   assign accept   = val_i && rdy_o;

   // Datapath: append the masked code to the accumulator and split off a full word.
   // The accumulator always holds cnt_q bits right-justified in stream-append order.
   always_comb begin
      code      = dat_i & ~({IN_WD{1'b1}} << len_i);
      code_ext  = ACC_WD'(code);
      new_cnt   = cnt_q + SUM_WD'(len_i);
      res_cnt   = new_cnt - DW_S;
      full      = (new_cnt >= DW_S);
      combined  = '0;
      word_full = '0;
      resid     = '0;
      if (LSB_FIRST) begin
         combined  = acc_q | (code_ext << cnt_q);
         word_full = combined[DATA_WD-1:0];
         resid     = combined >> DATA_WD;
      end else begin
         combined  = (acc_q << len_i) | code_ext;
         word_full = DATA_WD'(combined >> res_cnt);
         resid     = combined & ~({ACC_WD{1'b1}} << res_cnt);
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      dat_d   = dat_q;
      byt_d   = byt_q;
      lst_d   = lst_q;
      if (val_q && rdy_i) val_d = 1'b0;

      unique case (state_q)
         StRun: begin
            if (accept) begin
               if (full) begin
                  val_d = 1'b1;
                  dat_d = word_full;
                  byt_d = BYT_FULL;
                  lst_d = flush_i && (res_cnt == '0);
                  if (flush_i && (res_cnt == '0)) begin
                     acc_d = '0;
                     cnt_d = '0;
                  end else begin
                     acc_d = resid;
                     cnt_d = res_cnt;
                     // Residual still owes a word; stall input until it is out.
                     if (flush_i) state_d = StFlush;
                  end
               end else if (flush_i) begin
                  // Also covers new_cnt == 0: an empty last word keeps the stream terminated.
                  val_d = 1'b1;
                  dat_d = pad_word(combined[DATA_WD-1:0], new_cnt);
                  byt_d = ceil_bytes(new_cnt);
                  lst_d = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d = combined;
                  cnt_d = new_cnt;
               end
            end
         end
         StFlush: begin
            if (out_free) begin
               val_d   = 1'b1;
               dat_d   = pad_word(acc_q[DATA_WD-1:0], cnt_q);
               byt_d   = ceil_bytes(cnt_q);
               lst_d   = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StRun;
         acc_q   <= '0;
         cnt_q   <= '0;
         val_q   <= 1'b0;
         dat_q   <= '0;
         byt_q   <= '0;
         lst_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         dat_q   <= dat_d;
         byt_q   <= byt_d;
         lst_q   <= lst_d;
      end
   end

   assign val_o = val_q;
   assign dat_o = dat_q;
   assign byt_o = byt_q;
   assign lst_o = lst_q;

endmodule
